// File: rtl/bufr_div_pkg.sv
// Shared types, limits and helpers for the BUFR clock divider bank.
package bufr_div_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 16;
    localparam int unsigned CNT_WIDTH_MAX     = 32;
    localparam int unsigned MIN_DIV           = 2;

    // Period/high-time pair; held at the widest supported width so any CNT_WIDTH fits.
    typedef struct packed {
        logic [CNT_WIDTH_MAX-1:0] div;
        logic [CNT_WIDTH_MAX-1:0] high;
    } div_cfg_t;

    // A period below two cycles cannot produce a wave, so it is raised to the minimum.
    function automatic logic [CNT_WIDTH_MAX-1:0] clamp_div(input logic [CNT_WIDTH_MAX-1:0] div);
        return (div < CNT_WIDTH_MAX'(MIN_DIV)) ? CNT_WIDTH_MAX'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/bufr_div_channel.sv
// One divider channel: counter, active/shadow configuration and registered out/tick.
module bufr_div_channel
    import bufr_div_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_DIV  = 8,
    parameter int unsigned DEFAULT_HIGH = 4
) (
    input  logic                 bufr_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sel,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic                 pending,
    output logic                 out,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0]     cnt;
    div_cfg_t                 active;
    div_cfg_t                 shadow;
    logic [CNT_WIDTH_MAX-1:0] cnt_ext;
    logic                     wrap;
    logic                     apply;
    logic                     accept;

    // Compare at full struct width; cnt never exceeds div-1 so nothing overflows.
    assign cnt_ext = CNT_WIDTH_MAX'(cnt);
    assign wrap    = en & (cnt_ext == (active.div - CNT_WIDTH_MAX'(1)));
    // A waiting shadow loads on a wrap, or at once when the channel is idle.
    assign apply   = pending & (wrap | ~en);
    // Only one config can wait per channel; a request is refused while one is pending.
    assign accept  = sel & ~pending;

    // Counter, configuration handoff and output registers.
    always_ff @(posedge bufr_clk) begin
        if (rst) begin
            cnt         <= '0;
            active.div  <= CNT_WIDTH_MAX'(DEFAULT_DIV);
            active.high <= CNT_WIDTH_MAX'(DEFAULT_HIGH);
            shadow.div  <= CNT_WIDTH_MAX'(DEFAULT_DIV);
            shadow.high <= CNT_WIDTH_MAX'(DEFAULT_HIGH);
            pending     <= 1'b0;
            out         <= 1'b0;
            tick        <= 1'b0;
        end else begin
            out  <= en & (cnt_ext < active.high);
            tick <= wrap;
            if (apply) begin
                active <= shadow;
                cnt    <= '0;
            end else if (en) begin
                cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);
            end
            if (accept) begin
                shadow.div  <= clamp_div(CNT_WIDTH_MAX'(cfg_div));
                shadow.high <= CNT_WIDTH_MAX'(cfg_high);
            end
            pending <= accept | (pending & ~apply);
        end
    end

endmodule

// File: rtl/bufr_clk_divider_bank.sv
// Bank of independent programmable clock dividers driven from a BUFR output.
module bufr_clk_divider_bank
    import bufr_div_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_DIV  = 8,
    parameter int unsigned DEFAULT_HIGH = 4,
    localparam int unsigned CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 bufr_clk,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic [CHANNELS-1:0]  out,
    output logic [CHANNELS-1:0]  tick
);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] sel;

    // Ready reflects the addressed channel's slot; out-of-range targets are always accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (cfg_chan == CHAN_W'(c)) begin
                cfg_ready = ~pending[c];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign sel[g] = cfg_valid & (cfg_chan == CHAN_W'(g));

        bufr_div_channel #(
            .CNT_WIDTH    (CNT_WIDTH),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_HIGH (DEFAULT_HIGH)
        ) u_chan (
            .bufr_clk (bufr_clk),
            .rst      (rst),
            .en       (en[g]),
            .sel      (sel[g]),
            .cfg_div  (cfg_div),
            .cfg_high (cfg_high),
            .pending  (pending[g]),
            .out      (out[g]),
            .tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_bufr_clk_divider_bank.sv
// Self-checking bench for bufr_clk_divider_bank: behavioural model plus scoreboard queue.
module tb_bufr_clk_divider_bank;

    localparam int CH = 4;

    logic        bufr_clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic [3:0]  out;
    logic [3:0]  tick;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] tick;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  last_out;
    logic [3:0]  last_tick;

    int unsigned m_cnt[CH];
    int unsigned m_div[CH];
    int unsigned m_high[CH];
    int unsigned m_sdiv[CH];
    int unsigned m_shigh[CH];
    bit          m_pend[CH];

    bufr_clk_divider_bank dut (
        .bufr_clk  (bufr_clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .out       (out),
        .tick      (tick)
    );

    always #5 bufr_clk = ~bufr_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c]   = 0;
            m_div[c]   = 8;
            m_high[c]  = 4;
            m_sdiv[c]  = 8;
            m_shigh[c] = 4;
            m_pend[c]  = 1'b0;
        end
    endtask

    // One clock: check ready, advance the model, push the expectation, compare after the edge.
    task automatic step();
        exp_t e;
        bit   wrap;
        bit   acc;
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_chan]));
        e = '0;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                wrap      = en[c] && (m_cnt[c] == m_div[c] - 1);
                e.out[c]  = en[c] && (m_cnt[c] < m_high[c]);
                e.tick[c] = wrap;
                acc       = cfg_valid && (int'(cfg_chan) == c) && !m_pend[c];
                if (m_pend[c] && (wrap || !en[c])) begin
                    m_div[c]  = m_sdiv[c];
                    m_high[c] = m_shigh[c];
                    m_cnt[c]  = 0;
                    m_pend[c] = 1'b0;
                end else if (en[c]) begin
                    m_cnt[c] = wrap ? 0 : m_cnt[c] + 1;
                end
                if (acc) begin
                    m_sdiv[c]  = (cfg_div < 16'd2) ? 2 : 32'(cfg_div);
                    m_shigh[c] = 32'(cfg_high);
                    m_pend[c]  = 1'b1;
                end
            end
        end
        sb.push_back(e);
        @(posedge bufr_clk);
        #1;
        e         = sb.pop_front();
        last_out  = out;
        last_tick = tick;
        chk("out", 32'(out), 32'(e.out));
        chk("tick", 32'(tick), 32'(e.tick));
        @(negedge bufr_clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_hist(input int ch, input int n, output logic [15:0] ho, output logic [15:0] ht);
        ho = '0;
        ht = '0;
        repeat (n) begin
            step();
            ho = {ho[14:0], last_out[ch]};
            ht = {ht[14:0], last_tick[ch]};
        end
    endtask

    // Hold a request until the addressed slot frees up, bounded.
    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] d, input logic [15:0] h);
        bit done;
        cfg_chan  = ch;
        cfg_div   = d;
        cfg_high  = h;
        cfg_valid = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            done = cfg_ready;
            step();
        end
        cfg_valid = 1'b0;
        chk("cfg_accept", 32'(done), 32'd1);
    endtask

    initial begin
        logic [15:0] ho;
        logic [15:0] ht;
        rst       = 1'b1;
        en        = 4'h0;
        cfg_valid = 1'b0;
        cfg_chan  = 2'd0;
        cfg_div   = 16'd0;
        cfg_high  = 16'd0;
        model_reset();
        @(posedge bufr_clk);
        #1;
        @(negedge bufr_clk);
        step();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // Default 8/4 wave on all channels.
        rst = 1'b0;
        en  = 4'hF;
        run_hist(0, 16, ho, ht);
        chk("t1_wave", 32'(ho), 32'h0000_F0F0);
        chk("t1_tick", 32'(ht), 32'h0000_0101);
        chk("t1_phase", 32'(last_out), 32'd0);

        // Reprogram channel 1 mid-period, then a second request while pending.
        run(3);
        cfg_write(2'd1, 16'd5, 16'd2);
        cfg_valid = 1'b1;
        cfg_div   = 16'd3;
        cfg_high  = 16'd1;
        chk("t3_refused", 32'(cfg_ready), 32'd0);
        cfg_write(2'd1, 16'd3, 16'd1);
        run(12);

        // Boundary values on channel 0.
        cfg_write(2'd0, 16'd0, 16'd1);
        run(8);
        run_hist(0, 8, ho, ht);
        chk("t4_div2", 32'(ho[7:0] == 8'hAA || ho[7:0] == 8'h55), 32'd1);
        cfg_write(2'd0, 16'd6, 16'd0);
        run(8);
        run_hist(0, 12, ho, ht);
        chk("t4_high0", 32'(ho), 32'd0);
        cfg_write(2'd0, 16'd9, 16'd9);
        run(10);
        run_hist(0, 16, ho, ht);
        chk("t4_high_eq_div", 32'(ho), 32'h0000_FFFF);

        // Disable channel 2, resume, then configure while disabled.
        en = 4'hB;
        run_hist(2, 10, ho, ht);
        chk("t5_out_off", 32'(ho), 32'd0);
        chk("t5_tick_off", 32'(ht), 32'd0);
        en = 4'hF;
        run(6);
        en = 4'hB;
        run(2);
        cfg_write(2'd2, 16'd4, 16'd3);
        run(3);
        en = 4'hF;
        run_hist(2, 8, ho, ht);
        chk("t5_new_wave", 32'(ho), 32'h0000_00EE);
        chk("t5_new_tick", 32'(ht), 32'h0000_0011);

        // Reset with a pending config on channel 3.
        cfg_write(2'd3, 16'd7, 16'd1);
        rst = 1'b1;
        step();
        chk("t6_out", 32'(out), 32'd0);
        chk("t6_tick", 32'(tick), 32'd0);
        chk("t6_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        run_hist(3, 16, ho, ht);
        chk("t6_wave", 32'(ho), 32'h0000_F0F0);
        chk("t6_tick_wave", 32'(ht), 32'h0000_0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
